// File: rtl/sramlike_arbiter.sv
// sramlike_arbiter: shares one sram-like slave between instruction and data masters, one outstanding transaction.
// Define SRAMLIKE_ARB_RR_EN for round-robin tie-breaking; otherwise DATA has fixed priority over INST.
module sramlike_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0] state_q, state_d;
    logic       lock_v_q, lock_v_d;
    logic       lock_sel_q, lock_sel_d;
    logic       tie_sel, gnt_sel, gnt_v, idle, drive, accept;

`ifdef SRAMLIKE_ARB_RR_EN
    logic last_q, last_d;
    assign tie_sel = ~last_q;
    assign last_d  = accept ? gnt_sel : last_q;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) last_q <= 1'b0;
        else         last_q <= last_d;
`else
    assign tie_sel = 1'b1;
`endif

    // gnt_sel: 1 selects DATA, 0 selects INST
    assign gnt_sel = lock_v_q ? lock_sel_q : (data_req & inst_req) ? tie_sel : data_req;
    assign gnt_v   = lock_v_q | data_req | inst_req;
    assign idle    = resetn & (state_q == IDLE);
    assign drive   = idle & gnt_v;
    assign accept  = req & addr_ok;

    assign req   = drive & (gnt_sel ? data_req : inst_req);
    assign wr    = drive & (gnt_sel ? data_wr : inst_wr);
    assign size  = drive ? (gnt_sel ? data_size : inst_size) : 2'b0;
    assign addr  = drive ? (gnt_sel ? data_addr : inst_addr) : 32'b0;
    assign wdata = drive ? (gnt_sel ? data_wdata : inst_wdata) : 32'b0;

    assign inst_addr_ok = accept & ~gnt_sel;
    assign data_addr_ok = accept & gnt_sel;
    assign inst_data_ok = resetn & (state_q == BUSY_I) & data_ok;
    assign data_data_ok = resetn & (state_q == BUSY_D) & data_ok;
    assign inst_rdata   = inst_data_ok ? rdata : 32'b0;
    assign data_rdata   = data_data_ok ? rdata : 32'b0;

    // a completion cycle returns to IDLE without issuing; the next grant happens a cycle later
    assign state_d    = accept ? (gnt_sel ? BUSY_D : BUSY_I)
                      : (state_q != IDLE && data_ok) ? IDLE : state_q;
    assign lock_v_d   = idle ? (req & ~addr_ok) : lock_v_q;
    assign lock_sel_d = req ? gnt_sel : lock_sel_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            lock_v_q   <= 1'b0;
            lock_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_v_q   <= lock_v_d;
            lock_sel_q <= lock_sel_d;
        end
    end
endmodule
